// File: rtl/seg_scan_decoder_if.sv
// Pin-level bundle between a multiplexed 7-segment display driver and the scan decoder.
// The master side (tester/display) drives the pins and the slave side (decoder) reports captured frames.
interface seg_scan_decoder_if;
   logic [6:0]  seg_in;
   logic [3:0]  an_in;
   logic        led_in;
   logic [15:0] digits;
   logic [3:0]  blank;
   logic [3:0]  err;
   logic        frame_valid;
   logic        led_rise;

   modport master (
      output seg_in, an_in, led_in,
      input  digits, blank, err, frame_valid, led_rise
   );

   modport slave (
      input  seg_in, an_in, led_in,
      output digits, blank, err, frame_valid, led_rise
   );
endinterface

// File: rtl/seg_scan_decoder.sv
// Watches a scanned, active-low 4-digit 7-segment display and rebuilds the shown digits.
// A digit is captured once its pattern has been stable long enough; a full set of four is committed as a frame.
module seg_scan_decoder #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input logic clk,
   input logic rst_n,
   seg_scan_decoder_if.slave bus
);

   localparam logic [7:0] MAX_CNT = 8'(STABLE_CYCLES);

   logic [6:0]  s_seg, p_seg;
   logic [3:0]  s_an, p_an;
   logic [7:0]  cnt, cnt_next;
   logic        an_valid, same, capture;
   logic [1:0]  idx;
   logic [3:0]  nibble;
   logic        dec_blank, dec_err;
   logic [15:0] shadow_digits, digits;
   logic [3:0]  shadow_blank, shadow_err, blank, err, seen;
   logic        frame_valid;
   logic        led_s1, led_s2, led_d, led_rise;
   logic [2:0]  led_ok;

   always_comb begin
      an_valid = 1'b1;
      idx      = 2'd0;
      case (s_an)
         4'b1110: idx = 2'd0;
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: an_valid = 1'b0;
      endcase
   end

   always_comb begin
      nibble    = 4'hE;
      dec_blank = 1'b0;
      dec_err   = 1'b0;
      case (s_seg)
         7'h40: nibble = 4'h0;
         7'h79: nibble = 4'h1;
         7'h24: nibble = 4'h2;
         7'h30: nibble = 4'h3;
         7'h19: nibble = 4'h4;
         7'h12: nibble = 4'h5;
         7'h02: nibble = 4'h6;
         7'h78: nibble = 4'h7;
         7'h00: nibble = 4'h8;
         7'h10: nibble = 4'h9;
         7'h7F: begin
            nibble    = 4'hF;
            dec_blank = 1'b1;
         end
         default: dec_err = 1'b1;
      endcase
   end

   // The counter can only pass through MAX_CNT-1 once per dwell because it saturates above it.
   always_comb begin
      same = ({s_an, s_seg} == {p_an, p_seg});
      if (!an_valid || !same)
         cnt_next = 8'd0;
      else if (cnt >= MAX_CNT)
         cnt_next = MAX_CNT;
      else
         cnt_next = cnt + 8'd1;
      capture = (cnt_next == (MAX_CNT - 8'd1));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s_seg         <= '0;
         s_an          <= '0;
         p_seg         <= '0;
         p_an          <= '0;
         cnt           <= '0;
         shadow_digits <= 16'hFFFF;
         shadow_blank  <= 4'b1111;
         shadow_err    <= 4'b0000;
         seen          <= 4'b0000;
         digits        <= 16'hFFFF;
         blank         <= 4'b1111;
         err           <= 4'b0000;
         frame_valid   <= 1'b0;
      end else begin
         s_seg       <= bus.seg_in;
         s_an        <= bus.an_in;
         p_seg       <= s_seg;
         p_an        <= s_an;
         cnt         <= cnt_next;
         frame_valid <= (seen == 4'b1111);
         if (capture) begin
            shadow_digits[{idx, 2'b00} +: 4] <= nibble;
            shadow_blank[idx]                <= dec_blank;
            shadow_err[idx]                  <= dec_err;
         end
         // Commit reads the shadow before this edge's capture lands, so a coinciding capture starts the next frame.
         if (seen == 4'b1111) begin
            digits <= shadow_digits;
            blank  <= shadow_blank;
            err    <= shadow_err;
            seen   <= capture ? ~s_an : 4'b0000;
         end else if (capture) begin
            seen <= seen | ~s_an;
         end
      end
   end

   // led_ok tracks how far real samples have propagated since reset, so a line held high through reset is not an edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         led_s1   <= 1'b0;
         led_s2   <= 1'b0;
         led_d    <= 1'b0;
         led_ok   <= 3'b000;
         led_rise <= 1'b0;
      end else begin
         led_s1   <= bus.led_in;
         led_s2   <= led_s1;
         led_d    <= led_s2;
         led_ok   <= {led_ok[1:0], 1'b1};
         led_rise <= led_s2 & ~led_d & led_ok[2];
      end
   end

   assign bus.digits      = digits;
   assign bus.blank       = blank;
   assign bus.err         = err;
   assign bus.frame_valid = frame_valid;
   assign bus.led_rise    = led_rise;

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001: Parameter STABLE_CYCLES, default 4, sets how many consecutive cycles an anode/segment pattern must hold before capture; legal range 2..255.
REQ-002: clk  input  1  single system clock; all flops rising-edge.
REQ-003: rst_n  input  1  reset, synchronous, active-low.
REQ-004: seg_in  input  7  active-low segments; bit6..bit0 = g,f,e,d,c,b,a.
REQ-005: an_in  input  4  active-low digit anodes; an_in[i]=0 selects digit i.
REQ-006: led_in  input  1  stimulus LED line from the tester.
REQ-007: digits  output  16  captured frame; nibble i = digits[4i+3:4i] = digit i.
REQ-008: blank  output  4  per-digit flag; segments all off in the last frame.
REQ-009: err  output  4  per-digit flag; unrecognised pattern in the last frame.
REQ-010: frame_valid  output  1  one-cycle pulse when digits/blank/err update.
REQ-011: led_rise  output  1  one-cycle pulse on a synchronised 0->1 transition of led_in.

Function
REQ-012: seg_in and an_in pass through one register stage (s_seg, s_an) before any decision; led_in passes through two flops before edge detection.
REQ-013: A registered anode value is valid only when exactly one bit of s_an is 0; all-high or multiple-low values are invalid.
REQ-014: Stability counter: it resets to 0 when {s_an,s_seg} differs from the previous cycle or s_an is invalid; otherwise it increments, saturating at STABLE_CYCLES.
REQ-015: Capture fires on the single edge at which the counter reaches STABLE_CYCLES-1 with valid s_an; a pattern held longer captures exactly once per dwell.
REQ-016: Decode table, seg_in hex -> nibble: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9.
REQ-017: 7F decodes as blank: shadow nibble F, blank bit 1, err bit 0.
REQ-018: Any other pattern decodes as error: shadow nibble E, err bit 1, blank bit 0.
REQ-019: Capture writes the shadow nibble and flags for the selected digit and sets seen[i]; recapturing the same digit within a frame overwrites the shadow and leaves seen unchanged.
REQ-020: When seen becomes 4'b1111, on the next edge copy the shadow into digits/blank/err, pulse frame_valid for 1 cycle, and clear seen.
REQ-021: A capture coinciding with the frame-commit edge updates the shadow and sets seen for the next frame; the committed frame uses pre-capture shadow values.
REQ-022: Minimum latency is 1 + STABLE_CYCLES + 1 cycles from the fourth digit's pattern appearing on the pins to frame_valid.
REQ-023: Outputs hold between frames; only frame_valid and led_rise are pulses.
REQ-024: led_rise asserts 3 cycles after led_in rises (2 sync stages + edge register) and is independent of the display path.

Reset
REQ-025: While rst_n=0 at an edge: digits=16'hFFFF, blank=4'b1111, err=0, frame_valid=0, led_rise=0, seen=0, counter=0, shadow=all blank, sync flops=0.
REQ-026: Reset mid-frame discards partial captures; the first frame_valid after release requires all four digits to be captured anew.
REQ-027: led_in held high through reset release does not produce led_rise.

Verification
REQ-028: Scan an=E,D,B,7 with seg=79,24,30,19, 6 cycles per digit, STABLE_CYCLES=4 -> one frame_valid; digits=16'h4321, blank=0, err=0.
REQ-029: Same scan, but each digit is held only 3 cycles -> no capture, no frame_valid, outputs stay at reset values.
REQ-030: Digit 2 shows 7F and digit 0 shows 55 -> digits=16'hXFXE with X = driven values; blank=4'b0100, err=4'b0001.
REQ-031: an_in=4'b1100 (two low) held for 20 cycles between digits -> no capture; the frame completes normally afterwards.
REQ-032: Assert rst_n=0 after 3 digits are captured, release, then scan 4 digits -> exactly one frame_valid, and only after the full post-reset scan.
REQ-033: led_in 0->1 -> led_rise high for exactly 1 cycle, 3 cycles later; led_in held high -> no further pulses.
